// File: rtl/vsm_out_arbiter_if.sv
// Handshake bundle between the two VSM output requesters and the output-register arbiter.
// master = requester/stimulus side, slave = arbiter side.
interface vsm_out_arbiter_if;
    logic       Req0;
    logic [3:0] Data0;
    logic       Req1;
    logic [3:0] Data1;
    logic       Ack0;
    logic       Ack1;
    logic [3:0] IB;
    logic       LoadOut;
    logic       Busy;

    modport master (
        output Req0, Data0, Req1, Data1,
        input  Ack0, Ack1, IB, LoadOut, Busy
    );

    modport slave (
        input  Req0, Data0, Req1, Data1,
        output Ack0, Ack1, IB, LoadOut, Busy
    );
endinterface

// File: rtl/vsm_out_arbiter.sv
// Arbitrates CPU OUT (req 0) and debug (req 1) onto the VSM output register; grant edge -> LoadOut/Ack next cycle, all outputs registered.
// Requests wait while busy (LOAD + HOLD_CYCLES of HOLD); VSM_OUT_PRIORITY_EN selects fixed priority to req 0 instead of round-robin.
module vsm_out_arbiter #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 4
) (
    input  logic             MainClock,
    input  logic             invMainReset,
    vsm_out_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       ib_q, ib_d;
    logic             load_q, load_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             busy_q, busy_d;
    logic             gnt_vld;
    logic             gnt_idx;

`ifdef VSM_OUT_PRIORITY_EN
    always_comb begin
        gnt_vld = (state_q == IDLE) && (bus.Req0 || bus.Req1);
        gnt_idx = ~bus.Req0;
    end
`else
    logic last_q, last_d;

    // On a tie the requester served least recently wins.
    always_comb begin
        gnt_vld = (state_q == IDLE) && (bus.Req0 || bus.Req1);
        gnt_idx = (bus.Req0 && bus.Req1) ? ~last_q : bus.Req1;
        last_d  = gnt_vld ? gnt_idx : last_q;
    end

    always_ff @(posedge MainClock or negedge invMainReset) begin
        if (!invMainReset) last_q <= 1'b1;
        else               last_q <= last_d;
    end
`endif

    always_ff @(posedge MainClock or negedge invMainReset) begin
        if (!invMainReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (gnt_vld) state_d = LOAD;
            LOAD: begin
                cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                state_d = HOLD;
            end
            HOLD: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they line up with it once registered.
    always_comb begin
        load_d = (state_d == LOAD);
        ack0_d = gnt_vld && !gnt_idx;
        ack1_d = gnt_vld &&  gnt_idx;
        busy_d = (state_d != IDLE);
        ib_d   = ib_q;
        if (gnt_vld) ib_d = gnt_idx ? bus.Data1 : bus.Data0;
    end

    always_ff @(posedge MainClock or negedge invMainReset) begin
        if (!invMainReset) begin
            ib_q   <= '0;
            load_q <= 1'b0;
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            ib_q   <= ib_d;
            load_q <= load_d;
            ack0_q <= ack0_d;
            ack1_q <= ack1_d;
            busy_q <= busy_d;
        end
    end

    assign bus.IB      = ib_q;
    assign bus.LoadOut = load_q;
    assign bus.Ack0    = ack0_q;
    assign bus.Ack1    = ack1_q;
    assign bus.Busy    = busy_q;

endmodule

// File: tb/tb_vsm_out_arbiter.sv
// Bench for vsm_out_arbiter: directed table, corner sequences, and random traffic against a timing/fairness model.
module tb_vsm_out_arbiter;

    localparam int H = 4;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    vsm_out_arbiter_if bus0 ();
    vsm_out_arbiter_if bus1 ();

    vsm_out_arbiter #(.HOLD_CYCLES(H), .CNT_W(4)) u_dut (
        .MainClock   (clk),
        .invMainReset(rst_n),
        .bus         (bus0)
    );

    vsm_out_arbiter #(.HOLD_CYCLES(1), .CNT_W(4)) u_dut_h1 (
        .MainClock   (clk),
        .invMainReset(rst_n),
        .bus         (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string nm, input logic ld, input logic a0, input logic a1,
                           input logic [3:0] ib, input logic bsy);
        chk({nm, ".LoadOut"}, 32'(bus0.LoadOut), 32'(ld));
        chk({nm, ".Ack0"},    32'(bus0.Ack0),    32'(a0));
        chk({nm, ".Ack1"},    32'(bus0.Ack1),    32'(a1));
        chk({nm, ".IB"},      32'(bus0.IB),      32'(ib));
        chk({nm, ".Busy"},    32'(bus0.Busy),    32'(bsy));
    endtask

    // Model: a grant at edge g makes the block unavailable until edge g+H+2;
    // outputs after edge e show the pulse when e==g and Busy while e-g <= H.
    int         m_cyc;
    int         m_next_avail;
    int         m_g;
    logic       m_last;
    logic       m_win;
    logic [3:0] m_ib;

    task automatic model_reset();
        m_cyc = 0; m_next_avail = 0; m_g = -1000; m_last = 1'b1; m_win = 1'b0; m_ib = 4'h0;
    endtask

    task automatic model_edge(input logic r0, input logic [3:0] d0, input logic r1, input logic [3:0] d1);
        if (m_cyc >= m_next_avail && (r0 || r1)) begin
`ifdef VSM_OUT_PRIORITY_EN
            m_win = !r0;
`else
            m_win = (r0 && r1) ? !m_last : r1;
`endif
            m_last       = m_win;
            m_ib         = m_win ? d1 : d0;
            m_g          = m_cyc;
            m_next_avail = m_cyc + H + 2;
        end
        m_cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic       r0;
        logic [3:0] d0;
        logic       r1;
        logic [3:0] d1;
        logic       ld;
        logic       a0;
        logic       a1;
        logic [3:0] ib;
        logic       bsy;
    } vec_t;

    vec_t       tbl [12];
    int         pulse_at [4];
    logic       pulse_who [4];
    logic [3:0] pulse_ib [4];
    int         npulse;
    logic [3:0] exp_order;
    int         e;

    initial begin
        // Tie after reset: grant 0 at edge 0, grant 1 at edge 6; each requester drops Req after its Ack.
        tbl[0]  = '{1'b1, 4'h3, 1'b1, 4'hC, 1'b1, 1'b1, 1'b0, 4'h3, 1'b1};
        tbl[1]  = '{1'b0, 4'h3, 1'b1, 4'hC, 1'b0, 1'b0, 1'b0, 4'h3, 1'b1};
        tbl[2]  = '{1'b0, 4'h3, 1'b1, 4'hC, 1'b0, 1'b0, 1'b0, 4'h3, 1'b1};
        tbl[3]  = '{1'b0, 4'h3, 1'b1, 4'hC, 1'b0, 1'b0, 1'b0, 4'h3, 1'b1};
        tbl[4]  = '{1'b0, 4'h3, 1'b1, 4'hC, 1'b0, 1'b0, 1'b0, 4'h3, 1'b1};
        tbl[5]  = '{1'b0, 4'h3, 1'b1, 4'hC, 1'b0, 1'b0, 1'b0, 4'h3, 1'b0};
        tbl[6]  = '{1'b0, 4'h3, 1'b1, 4'hC, 1'b1, 1'b0, 1'b1, 4'hC, 1'b1};
        tbl[7]  = '{1'b0, 4'h3, 1'b0, 4'hC, 1'b0, 1'b0, 1'b0, 4'hC, 1'b1};
        tbl[8]  = '{1'b0, 4'h3, 1'b0, 4'hC, 1'b0, 1'b0, 1'b0, 4'hC, 1'b1};
        tbl[9]  = '{1'b0, 4'h3, 1'b0, 4'hC, 1'b0, 1'b0, 1'b0, 4'hC, 1'b1};
        tbl[10] = '{1'b0, 4'h3, 1'b0, 4'hC, 1'b0, 1'b0, 1'b0, 4'hC, 1'b1};
        tbl[11] = '{1'b0, 4'h3, 1'b0, 4'hC, 1'b0, 1'b0, 1'b0, 4'hC, 1'b0};

        rst_n = 1'b0;
        bus0.Req0 = 1'b0; bus0.Data0 = 4'h0; bus0.Req1 = 1'b0; bus0.Data1 = 4'h0;
        bus1.Req0 = 1'b0; bus1.Data0 = 4'h0; bus1.Req1 = 1'b0; bus1.Data1 = 4'h0;
        #3;
        chk_out("reset", 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);

        // Tie table
        do_reset();
        for (int k = 0; k < 12; k++) begin
            bus0.Req0 = tbl[k].r0; bus0.Data0 = tbl[k].d0;
            bus0.Req1 = tbl[k].r1; bus0.Data1 = tbl[k].d1;
            cyc();
            chk_out($sformatf("tie[%0d]", k), tbl[k].ld, tbl[k].a0, tbl[k].a1, tbl[k].ib, tbl[k].bsy);
        end

        // Single write, then Data0 changes during HOLD must not reach IB
        bus0.Req0 = 1'b1; bus0.Data0 = 4'h5;
        cyc();
        chk_out("single.load", 1'b1, 1'b1, 1'b0, 4'h5, 1'b1);
        bus0.Req0 = 1'b0; bus0.Data0 = 4'hF;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            chk_out($sformatf("single.c%0d", k + 1), 1'b0, 1'b0, 1'b0, 4'h5, (k <= 4));
        end

        // Fairness: both held high for four grants
        do_reset();
        bus0.Req0 = 1'b1; bus0.Data0 = 4'h3; bus0.Req1 = 1'b1; bus0.Data1 = 4'hC;
        npulse = 0;
        for (int k = 0; k < 40 && npulse < 4; k++) begin
            cyc();
            if (bus0.LoadOut) begin
                pulse_at[npulse]  = k;
                pulse_who[npulse] = bus0.Ack1;
                pulse_ib[npulse]  = bus0.IB;
                npulse++;
            end
        end
        bus0.Req0 = 1'b0; bus0.Req1 = 1'b0;
        chk("fair.count", 32'(npulse), 32'd4);
`ifdef VSM_OUT_PRIORITY_EN
        exp_order = 4'b0000;
`else
        exp_order = 4'b1010;
`endif
        for (int k = 0; k < npulse; k++) begin
            chk($sformatf("fair.who[%0d]", k), 32'(pulse_who[k]), 32'(exp_order[k]));
            chk($sformatf("fair.ib[%0d]", k), 32'(pulse_ib[k]), exp_order[k] ? 32'hC : 32'h3);
            chk($sformatf("fair.at[%0d]", k), 32'(pulse_at[k]), 32'(k * (H + 2)));
        end

        // Reset mid-HOLD clears outputs without a clock edge; debug request granted after release
        do_reset();
        bus0.Req0 = 1'b1; bus0.Data0 = 4'h7;
        cyc();
        bus0.Req0 = 1'b0;
        cyc();
        cyc();
        chk_out("pre_rst", 1'b0, 1'b0, 1'b0, 4'h7, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk_out("rst_hold", 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        bus0.Req1 = 1'b1; bus0.Data1 = 4'hA;
        @(negedge clk);
        #2 rst_n = 1'b1;
        cyc();
        chk_out("rst_regrant", 1'b1, 1'b0, 1'b1, 4'hA, 1'b1);
        bus0.Req1 = 1'b0;

        // Reset mid-LOAD with Req0 still high: the abandoned grant is reissued
        do_reset();
        bus0.Req0 = 1'b1; bus0.Data0 = 4'h9;
        cyc();
        #2 rst_n = 1'b0;
        #1 chk_out("rst_load", 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        cyc();
        chk_out("rst_load_regrant", 1'b1, 1'b1, 1'b0, 4'h9, 1'b1);
        bus0.Req0 = 1'b0;

        // HOLD_CYCLES=1 instance: Req0 held for two writes
        do_reset();
        bus1.Req0 = 1'b1; bus1.Data0 = 4'h6;
        npulse = 0;
        for (int k = 0; k < 20 && npulse < 2; k++) begin
            cyc();
            if (bus1.LoadOut) begin
                pulse_at[npulse] = k;
                npulse++;
            end
        end
        bus1.Req0 = 1'b0;
        chk("h1.count", 32'(npulse), 32'd2);
        if (npulse == 2) chk("h1.gap", 32'(pulse_at[1] - pulse_at[0]), 32'd3);
        chk("h1.ib", 32'(bus1.IB), 32'h6);

        // Random traffic against the model, with occasional async resets
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            model_edge(bus0.Req0, bus0.Data0, bus0.Req1, bus0.Data1);
            @(negedge clk);
            e = m_cyc - 1;
            chk_out("rand", (m_g == e), (m_g == e) && !m_win, (m_g == e) && m_win,
                    m_ib, (e - m_g) <= H);
            if (bus0.Ack0) begin
                if ($urandom_range(3) != 0) bus0.Req0 = 1'b0;
                else bus0.Data0 = 4'($urandom_range(15));
            end else if (!bus0.Req0 && $urandom_range(2) == 0) begin
                bus0.Req0 = 1'b1; bus0.Data0 = 4'($urandom_range(15));
            end
            if (bus0.Ack1) begin
                if ($urandom_range(3) != 0) bus0.Req1 = 1'b0;
                else bus0.Data1 = 4'($urandom_range(15));
            end else if (!bus0.Req1 && $urandom_range(2) == 0) begin
                bus0.Req1 = 1'b1; bus0.Data1 = 4'($urandom_range(15));
            end
            if ($urandom_range(199) == 0) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
                model_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
